// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the issue shells (fadd, and later fmul/fdiv).
// Contents:
//   fp32_t    - raw IEEE-754 single-precision word
//   OP_ADD/SUB- request opcode encodings
//   FADD_LAT  - fixed latency of the adder core, in cycles
//   fneg()    - sign flip, applied to every encoding including NaN and Inf
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FADD_LAT = 2;

  // Pure bit operation: NaN payloads and infinities keep every other bit.
  function automatic fp32_t fneg(input fp32_t x);
    return {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// In-order response FIFO shared by the FPU issue shells.
// Ports:
//   clk, rstn          - clock, synchronous active-low reset
//   push_i, data_i     - write one entry (caller guarantees it is not full)
//   pop_i              - remove the head entry (caller guarantees not empty)
//   count_o            - number of stored entries, 0..DEPTH
//   data_o             - head entry, read straight from the storage registers
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_rsp_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

endmodule

// File: rtl/fadd_issue.sv
// Request/response shell for the two-stage pipelined FP adder core.
// Ports:
//   clk, rstn                       - clock, synchronous active-low reset
//   req_valid/req_ready             - request handshake
//   req_op, req_x1, req_x2, req_tag - request payload (op 1 = x1 - x2)
//   core_x1, core_x2                - operands to the adder core (combinational)
//   core_y, core_ovf                - core result, valid FADD_LAT cycles later
//   rsp_valid/rsp_ready             - response handshake
//   rsp_y, rsp_ovf, rsp_tag         - response payload, zero while idle
// Issue is credit based: a request is only accepted when the FIFO is sure to
// have room for it, because the core cannot be stalled.
module fadd_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      core_x1,
  output logic [31:0]      core_x2,
  input  logic [31:0]      core_y,
  input  logic             core_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int DW    = 33 + TAG_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic             accept;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic [CNT_W-1:0] fifo_count;
  logic [DW-1:0]    fifo_head;
  logic [SUM_W-1:0] inflight;

  // Subtraction is folded into a sign flip of the second operand.
  assign core_x1 = req_x1;
  assign core_x2 = (req_op == OP_SUB) ? fneg(req_x2) : req_x2;

  assign accept = req_valid & req_ready;

  // Entries already in the FIFO plus those still inside the core pipeline.
  // Only registered state counts, so a same-cycle pop frees nothing yet.
  assign inflight  = SUM_W'(fifo_count) + SUM_W'(v1_q) + SUM_W'(v2_q);
  assign req_ready = (inflight < SUM_W'(DEPTH));

  // Valid/tag shift pipe mirroring the core's fixed two-cycle latency.
  always_comb begin
    v1_d   = accept;
    tag1_d = req_tag;
    v2_d   = v1_q;
    tag2_d = tag1_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  fpu_rsp_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (v2_q),
    .data_i  ({core_y, core_ovf, tag2_q}),
    .pop_i   (rsp_valid & rsp_ready),
    .count_o (fifo_count),
    .data_o  (fifo_head)
  );

  // Head storage is never cleared, so the payload is masked while idle.
  assign rsp_valid = (fifo_count != '0);
  assign rsp_y     = rsp_valid ? fifo_head[DW-1 -: 32] : 32'h0;
  assign rsp_ovf   = rsp_valid ? fifo_head[TAG_W]      : 1'b0;
  assign rsp_tag   = rsp_valid ? fifo_head[TAG_W-1:0]  : '0;

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue with a behavioural two-cycle adder core.
// Expected responses are queued when a request is accepted and compared when
// the shell hands a response out.
module tb_fadd_issue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_x1, req_x2;
  logic [3:0]  req_tag;
  logic [31:0] core_x1, core_x2, core_y;
  logic        core_ovf;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_ovf;
  logic [3:0]  rsp_tag;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t       expQ[$];
  int         respCyc[$];
  logic [3:0] respTag[$];
  int         cyc = 0;
  int         checkCount = 0;
  int         passCount = 0;
  logic [32:0] s1, s2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fadd_issue #(.TAG_W(4), .DEPTH(4)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_tag   (req_tag),
    .core_x1   (core_x1),
    .core_x2   (core_x2),
    .core_y    (core_y),
    .core_ovf  (core_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_ovf   (rsp_ovf),
    .rsp_tag   (rsp_tag)
  );

  // Stand-in adder: exact for the directed float cases, a fixed mix otherwise.
  function automatic logic [32:0] coreFn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 1'b0};
    if (a == 32'h40400000 && b == 32'hBF800000) return {32'h40000000, 1'b0};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 1'b1};
    return {a ^ {b[15:0], b[31:16]}, a[0] & b[0]};
  endfunction

  // Two-stage core pipeline: operands of cycle t appear in cycle t+2.
  always @(posedge clk) begin
    s1 <= coreFn(core_x1, core_x2);
    s2 <= s1;
  end
  assign core_y   = s2[32:1];
  assign core_ovf = s2[0];

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) begin
      passCount = passCount + 1;
    end else begin
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic op, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [3:0] tag);
    @(posedge clk);
    #1;
    req_valid = v;
    req_op    = op;
    req_x1    = x1;
    req_x2    = x2;
    req_tag   = tag;
  endtask

  // Scoreboard: pop/compare responses, then queue the result of any accept.
  always @(negedge clk) begin
    rsp_t e;
    logic [31:0] x2eff;
    if (!rstn) begin
      expQ.delete();
    end else begin
      if (rsp_valid === 1'b1 && rsp_ready) begin
        respCyc.push_back(cyc);
        respTag.push_back(rsp_tag);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_y", {32'd0, rsp_y}, {32'd0, e.y});
          checkOutput("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
          checkOutput("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
        end
      end else if (rsp_valid === 1'b0) begin
        checkOutput("rsp_idle_zero", {27'd0, rsp_y, rsp_ovf, rsp_tag}, 64'd0);
      end
      if (req_valid && req_ready === 1'b1) begin
        x2eff = req_op ? {~req_x2[31], req_x2[30:0]} : req_x2;
        e = {coreFn(req_x1, x2eff), req_tag};
        expQ.push_back(e);
      end
    end
  end

  int         c0;
  int         acceptCount;
  logic [3:0] nextTag;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = 1'b0;
    req_x1 = '0; req_x2 = '0; req_tag = '0; rsp_ready = 1'b1;

    // Reset values
    @(posedge clk); @(negedge clk);
    checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset_rsp_payload", {27'd0, rsp_y, rsp_ovf, rsp_tag}, 64'd0);
    @(posedge clk); #1; rstn = 1'b1;

    // Add with latency check
    applyStimulus(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd5);
    @(negedge clk);
    c0 = cyc;
    checkOutput("add_core_x1", {32'd0, core_x1}, 64'h3F800000);
    checkOutput("add_core_x2", {32'd0, core_x2}, 64'h40000000);
    checkOutput("add_req_ready", {63'd0, req_ready}, 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("add_lat_valid_c%0d", k), {63'd0, rsp_valid},
                  (k == 3) ? 64'd1 : 64'd0);
    end
    checkOutput("add_lat_cycle", 64'(cyc - c0), 64'd3);

    // Sub: sign flip of x2 visible in the accept cycle
    applyStimulus(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 4'd6);
    @(negedge clk);
    checkOutput("sub_core_x2", {32'd0, core_x2}, 64'hBF800000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (4) @(negedge clk);

    // Overflow
    applyStimulus(1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd7);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (5) @(negedge clk);

    // Streaming: 8 back-to-back requests
    respCyc.delete(); respTag.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'(i), 32'h10000000 + 32'(i * 32'h111),
                    32'h02000000 ^ 32'(i), 4'(i));
      @(negedge clk);
      if (i == 0) c0 = cyc;
      checkOutput($sformatf("stream_ready_%0d", i), {63'd0, req_ready}, 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (6) @(negedge clk);
    checkOutput("stream_rsp_count", 64'(respCyc.size()), 64'd8);
    for (int i = 0; i < 8 && i < respCyc.size(); i++) begin
      checkOutput($sformatf("stream_cycle_%0d", i), 64'(respCyc[i] - c0), 64'(3 + i));
      checkOutput($sformatf("stream_tag_%0d", i), {60'd0, respTag[i]}, 64'(i));
    end

    // Backpressure: exactly DEPTH accepts with rsp_ready low
    acceptCount = 0;
    nextTag = 4'd8;
    @(posedge clk); #1; rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, nextTag[0], 32'h20000000 | 32'(nextTag),
                    32'h01230000 | 32'(nextTag), nextTag);
      @(negedge clk);
      if (req_ready) begin
        acceptCount = acceptCount + 1;
        nextTag = nextTag + 4'd1;
      end
    end
    checkOutput("bp_accepts", 64'(acceptCount), 64'd4);
    checkOutput("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
    checkOutput("bp_fifo_count", 64'(u_dut.fifo_count), 64'd4);
    checkOutput("bp_head_tag_stable", {60'd0, rsp_tag}, 64'd8);
    @(posedge clk); #1; rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_during_pop", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    checkOutput("bp_ready_after_pop", {63'd0, req_ready}, 64'd1);
    repeat (6) @(negedge clk);
    checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

    // Reset mid-flight: both in-flight results must be discarded
    applyStimulus(1'b1, 1'b0, 32'h30000000, 32'h30000001, 4'd12);
    applyStimulus(1'b1, 1'b1, 32'h30000002, 32'h30000003, 4'd13);
    @(posedge clk); #1; req_valid = 1'b0; rstn = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_rsp_valid_%0d", k), {63'd0, rsp_valid}, 64'd0);
      checkOutput($sformatf("rst_req_ready_%0d", k), {63'd0, req_ready}, 64'd1);
    end

    // Recovery after reset
    applyStimulus(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd14);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (5) @(negedge clk);
    checkOutput("final_drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fadd_issue.md
# fadd_issue

Request/response shell that initiates operations on the team's two-stage pipelined FP adder core. It accepts add/sub requests over a valid/ready handshake, folds subtraction into a sign flip of `x2`, and tracks in-flight operations by tag. Results land in a response FIFO; credit-based issue guarantees the fixed-latency core never produces a result with nowhere to go. It sits between the FPU dispatch logic and the adder core, which is instantiated beside it at the FPU top level.

## Interface
- `TAG_W`, default 4: width of the request/response tag.
- `DEPTH`, default 4: response FIFO entries; power of two, ≥2; ≥4 required for 1 op/cycle.
- `clk` in 1: clock; all logic is on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_op` in 1: 0 = add, 1 = sub (`x1 - x2`).
- `req_x1`, `req_x2` in 32: IEEE-754 single operands.
- `req_tag` in TAG_W: returned unchanged with the result.
- `core_x1`, `core_x2` out 32: adder core operands; the core samples them every cycle.
- `core_y` in 32, `core_ovf` in 1: adder core result and overflow flag.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_y` out 32, `rsp_ovf` out 1, `rsp_tag` out TAG_W: response payload.

## Operation
- **Operand path** (combinational):
  - `core_x1 = req_x1`.
  - `core_x2 = req_op ? {~req_x2[31], req_x2[30:0]} : req_x2`, including NaN and Inf.
- **Core contract**: operands presented in cycle t are valid on `core_y`/`core_ovf` in cycle t+2. The core has no stall and no valid signal.
- **In-flight tracking**:
  - Two-entry valid/tag shift pipe. `v1`/`tag1` load the accept/`req_tag` at the end of t; `v2`/`tag2` load `v1`/`tag1` at the end of t+1.
  - When `v2` is set in cycle t+2, `{core_y, core_ovf, tag2}` is pushed into the FIFO.
- **Credit**: `req_ready = (count + v1 + v2) < DEPTH`.
  - Computed from registered state only; a same-cycle pop does not free a credit.
  - Therefore a push into a full FIFO cannot occur.
- **FIFO**: DEPTH entries, in order, registered head.
  - `rsp_valid = (count != 0)`.
  - `rsp_y`, `rsp_ovf` and `rsp_tag` are forced to 0 while `rsp_valid` is 0.
  - On simultaneous push and pop, `count` is unchanged and the pointers both advance, wrapping mod DEPTH.
- **Ordering**: responses leave in exact acceptance order; no reordering and no drops.
- **No operation-level FSM**: state is `v1`, `v2`, `tag1`, `tag2`, the read/write pointers and `count`.
- **Reset** (`rstn` = 0 at an edge):
  - Clears `v1`, `v2`, pointers and `count`. FIFO storage need not be cleared.
  - In-flight operations are discarded; their core results arriving after reset are never pushed.
  - Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_y` = 0, `rsp_ovf` = 0, `rsp_tag` = 0.
  - `core_x1`/`core_x2` follow the request inputs even during reset.

## Timing
- **Latency**: accept at the edge ending cycle t → `rsp_valid` in cycle t+3, provided the FIFO was empty.
- **Throughput**: 1 accept/cycle sustained with `rsp_ready` = 1 and DEPTH ≥ 4. With DEPTH = 2, at most 2 ops are in flight.
- **Backpressure**: with `rsp_ready` = 0, exactly DEPTH requests are accepted, then `req_ready` falls. It rises again the cycle after the first pop.
- **`req_ready`** depends only on registered state and never combinationally on `req_valid` or `rsp_ready`.
- **Stability**: `rsp_*` hold stable while `rsp_valid & !rsp_ready`.

## Structure
- **Shared package `fpu_pkg`**:
  - `OP_ADD` = 1'b0, `OP_SUB` = 1'b1.
  - `FADD_LAT` = 2.
  - Function `fneg(x)` for the sign flip.
  - The 32-bit float word type.
- **One sub-module `fpu_rsp_fifo`**:
  - Parameterized by width (33+TAG_W) and DEPTH.
  - Exposes `push`, `pop`, `count`, and the head data.
  - Reused later by the fmul/fdiv issue shells.
- **Adder core**: not instantiated here; the FPU top wires the `core_*` ports.

## Test plan
- **Add**: `req_x1` = 0x3F800000, `req_x2` = 0x40000000, op = add, tag = 5 → 3 cycles later `rsp_y` = 0x40400000, `rsp_ovf` = 0, `rsp_tag` = 5.
- **Sub**: `req_x1` = 0x40400000, `req_x2` = 0x3F800000, op = sub → `core_x2` = 0xBF800000 in the accept cycle; `rsp_y` = 0x40000000.
- **Streaming**: 8 back-to-back requests with tags 0..7 and `rsp_ready` = 1 → `req_ready` stays 1; responses with tags 0..7 on 8 consecutive cycles starting 3 cycles after the first accept.
- **Backpressure**: `rsp_ready` = 0, `req_valid` held high → exactly 4 accepts, then `req_ready` = 0 and FIFO count = 4. Raise `rsp_ready` → 4 in-order responses, `req_ready` returns to 1 the cycle after the first pop, and there is no overflow.
- **Overflow**: 0x7F7FFFFF + 0x7F7FFFFF → `rsp_y` = 0x7F800000, `rsp_ovf` = 1.
- **Reset mid-flight**: accept 2 requests, drive `rstn` = 0 for 1 cycle the next cycle → `rsp_valid` stays 0 for the next 5 cycles, `req_ready` = 1, and no stale tag is ever emitted.
